// File: rtl/arbitro_pin.sv
// Two-keypad arbiter for a shared PIN verifier: round-robin grant, digit muxing,
// idle timeout, per-keypad failure counting and timed lockout.
module arbitro_pin #(
   parameter int unsigned TIMEOUT_CICLOS = 16,
   parameter int unsigned MAX_FALLOS     = 3,
   parameter int unsigned BLOQUEO_CICLOS = 64
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       SOLICITUD_A,
   input  logic       SOLICITUD_B,
   input  logic [3:0] DIGITO_A,
   input  logic [3:0] DIGITO_B,
   input  logic       DIGITO_STB_A,
   input  logic       DIGITO_STB_B,
   output logic       SOLICITUD_ACCESO,
   output logic [3:0] DIGITO,
   output logic       DIGITO_STB,
   input  logic       ACCESO_ACEPTADO,
   input  logic       ACCESO_DENEGADO,
   output logic       CONCEDIDO_A,
   output logic       CONCEDIDO_B,
   output logic       ACEPTADO_A,
   output logic       ACEPTADO_B,
   output logic       DENEGADO_A,
   output logic       DENEGADO_B,
   output logic       BLOQUEADO_A,
   output logic       BLOQUEADO_B
);

   localparam int unsigned TW = $clog2(TIMEOUT_CICLOS + 1);
   localparam int unsigned FW = $clog2(MAX_FALLOS + 1);
   localparam int unsigned BW = $clog2(BLOQUEO_CICLOS + 1);

   typedef enum logic [1:0] {LIBRE, INICIO, SESION, CIERRE} estado_t;

   estado_t estado, estado_sig;

   // Requester index: 0 = A, 1 = B
   logic          dueno, dueno_sig;
   logic          ultimo;
   logic [1:0]    solicitud, stb, elegible;
   logic [1:0]    bloqueado, aceptado_q, denegado_q;
   logic [FW-1:0] fallos   [2];
   logic [BW-1:0] bloq_cnt [2];
   logic [TW-1:0] ocioso;

   logic       owner_stb, fin_acept, fin_deneg, fin_tmo, fallo;
   logic       solicitud_acceso;
   logic [1:0] concedido;
   logic [3:0] digito;
   logic       digito_stb;

   assign solicitud = {SOLICITUD_B, SOLICITUD_A};
   assign stb       = {DIGITO_STB_B, DIGITO_STB_A};
   assign elegible  = solicitud & ~bloqueado;
   assign owner_stb = stb[dueno];

   // Denial beats acceptance; an explicit result beats the timeout.
   assign fin_deneg = (estado == SESION) && ACCESO_DENEGADO;
   assign fin_acept = (estado == SESION) && ACCESO_ACEPTADO && !ACCESO_DENEGADO;
   assign fin_tmo   = (estado == SESION) && !ACCESO_ACEPTADO && !ACCESO_DENEGADO &&
                      !owner_stb && (ocioso == TW'(TIMEOUT_CICLOS - 1));
   assign fallo     = fin_deneg || fin_tmo;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         estado <= LIBRE;
         dueno  <= 1'b0;
      end else begin
         estado <= estado_sig;
         dueno  <= dueno_sig;
      end
   end

   always_comb begin
      estado_sig = estado;
      dueno_sig  = dueno;
      case (estado)
         LIBRE: begin
            if (elegible == 2'b11) begin
               dueno_sig  = ~ultimo;
               estado_sig = INICIO;
            end else if (elegible[0]) begin
               dueno_sig  = 1'b0;
               estado_sig = INICIO;
            end else if (elegible[1]) begin
               dueno_sig  = 1'b1;
               estado_sig = INICIO;
            end
         end
         INICIO:  estado_sig = SESION;
         SESION:  if (fin_acept || fallo) estado_sig = CIERRE;
         CIERRE:  estado_sig = LIBRE;
         default: estado_sig = LIBRE;
      endcase
   end

   always_comb begin
      solicitud_acceso = 1'b0;
      concedido        = '0;
      digito           = '0;
      digito_stb       = 1'b0;
      case (estado)
         INICIO: begin
            solicitud_acceso = 1'b1;
            concedido[dueno] = 1'b1;
         end
         SESION: begin
            concedido[dueno] = 1'b1;
            digito           = dueno ? DIGITO_B : DIGITO_A;
            digito_stb       = owner_stb;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         ultimo     <= 1'b1;
         ocioso     <= '0;
         aceptado_q <= '0;
         denegado_q <= '0;
         bloqueado  <= '0;
         for (int unsigned i = 0; i < 2; i++) begin
            fallos[i]   <= '0;
            bloq_cnt[i] <= '0;
         end
      end else begin
         if (estado == CIERRE) ultimo <= dueno;

         if (estado == SESION && !owner_stb && ocioso != TW'(TIMEOUT_CICLOS))
            ocioso <= ocioso + 1'b1;
         else
            ocioso <= '0;

         for (int unsigned i = 0; i < 2; i++) begin
            aceptado_q[i] <= fin_acept && (dueno == 1'(i));
            denegado_q[i] <= fallo && (dueno == 1'(i));

            // Lockout is armed while closing the session that hit the limit.
            if (estado == CIERRE && dueno == 1'(i) && fallos[i] == FW'(MAX_FALLOS)) begin
               bloqueado[i] <= 1'b1;
               bloq_cnt[i]  <= BW'(BLOQUEO_CICLOS);
               fallos[i]    <= '0;
            end else begin
               if (bloqueado[i]) begin
                  if (bloq_cnt[i] == '0) bloqueado[i] <= 1'b0;
                  else                   bloq_cnt[i]  <= bloq_cnt[i] - 1'b1;
               end
               if (fin_acept && dueno == 1'(i))
                  fallos[i] <= '0;
               else if (fallo && dueno == 1'(i) && fallos[i] != FW'(MAX_FALLOS))
                  fallos[i] <= fallos[i] + 1'b1;
            end
         end
      end
   end

   assign SOLICITUD_ACCESO = solicitud_acceso;
   assign DIGITO           = digito;
   assign DIGITO_STB       = digito_stb;
   assign CONCEDIDO_A      = concedido[0];
   assign CONCEDIDO_B      = concedido[1];
   assign ACEPTADO_A       = aceptado_q[0];
   assign ACEPTADO_B       = aceptado_q[1];
   assign DENEGADO_A       = denegado_q[0];
   assign DENEGADO_B       = denegado_q[1];
   assign BLOQUEADO_A      = bloqueado[0];
   assign BLOQUEADO_B      = bloqueado[1];

endmodule

// File: tb/tb_arbitro_pin.sv
// Scoreboard bench for arbitro_pin: stimulus queues expected grants, digits and
// result pulses; a negedge monitor pops and compares whenever the DUT presents them.
module tb_arbitro_pin;

   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic       SOLICITUD_A = 1'b0, SOLICITUD_B = 1'b0;
   logic [3:0] DIGITO_A = '0, DIGITO_B = '0;
   logic       DIGITO_STB_A = 1'b0, DIGITO_STB_B = 1'b0;
   logic       ACCESO_ACEPTADO = 1'b0, ACCESO_DENEGADO = 1'b0;
   logic       SOLICITUD_ACCESO, DIGITO_STB;
   logic [3:0] DIGITO;
   logic       CONCEDIDO_A, CONCEDIDO_B, ACEPTADO_A, ACEPTADO_B;
   logic       DENEGADO_A, DENEGADO_B, BLOQUEADO_A, BLOQUEADO_B;

   arbitro_pin #(.TIMEOUT_CICLOS(16), .MAX_FALLOS(3), .BLOQUEO_CICLOS(64)) dut (
      .CLK(CLK), .RESET(RESET),
      .SOLICITUD_A(SOLICITUD_A), .SOLICITUD_B(SOLICITUD_B),
      .DIGITO_A(DIGITO_A), .DIGITO_B(DIGITO_B),
      .DIGITO_STB_A(DIGITO_STB_A), .DIGITO_STB_B(DIGITO_STB_B),
      .SOLICITUD_ACCESO(SOLICITUD_ACCESO), .DIGITO(DIGITO), .DIGITO_STB(DIGITO_STB),
      .ACCESO_ACEPTADO(ACCESO_ACEPTADO), .ACCESO_DENEGADO(ACCESO_DENEGADO),
      .CONCEDIDO_A(CONCEDIDO_A), .CONCEDIDO_B(CONCEDIDO_B),
      .ACEPTADO_A(ACEPTADO_A), .ACEPTADO_B(ACEPTADO_B),
      .DENEGADO_A(DENEGADO_A), .DENEGADO_B(DENEGADO_B),
      .BLOQUEADO_A(BLOQUEADO_A), .BLOQUEADO_B(BLOQUEADO_B)
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;
   int blk_b  = 0;

   // Grant: {CONCEDIDO_A, CONCEDIDO_B}; result: {ACEPTADO_A, ACEPTADO_B, DENEGADO_A, DENEGADO_B}
   logic [1:0] q_grant [$];
   logic [3:0] q_dig   [$];
   logic [3:0] q_res   [$];

   logic       prev_sol = 1'b0;
   logic [3:0] prev_res = '0;
   logic [3:0] res_now;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
      end
   endtask

   task automatic fail_ev(input string n, input logic [31:0] act);
      checks++;
      errors++;
      $display("FAIL %s: got %0h with nothing expected at %0t", n, act, $time);
   endtask

   always @(negedge CLK) begin
      if (!RESET) begin
         prev_sol = 1'b0;
         prev_res = '0;
      end else begin
         res_now = {ACEPTADO_A, ACEPTADO_B, DENEGADO_A, DENEGADO_B};
         if (SOLICITUD_ACCESO) begin
            chk("sol_acceso_width", 32'(prev_sol), 0);
            if (q_grant.size() == 0) fail_ev("grant_unexpected", {CONCEDIDO_A, CONCEDIDO_B});
            else chk("grant", {CONCEDIDO_A, CONCEDIDO_B}, q_grant.pop_front());
         end
         if (DIGITO_STB) begin
            if (q_dig.size() == 0) fail_ev("digit_unexpected", DIGITO);
            else chk("digit", DIGITO, q_dig.pop_front());
         end
         if (res_now != 0) begin
            chk("result_width", prev_res, 0);
            if (q_res.size() == 0) fail_ev("result_unexpected", res_now);
            else chk("result", res_now, q_res.pop_front());
         end
         prev_sol = SOLICITUD_ACCESO;
         prev_res = res_now;
      end
      if (BLOQUEADO_B) blk_b++;
   end

   task automatic ciclo();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_req(input bit who, input logic v);
      if (who) SOLICITUD_B = v;
      else     SOLICITUD_A = v;
   endtask

   task automatic chk_cero(input string n);
      chk(n, {SOLICITUD_ACCESO, DIGITO, DIGITO_STB, CONCEDIDO_A, CONCEDIDO_B, ACEPTADO_A,
              ACEPTADO_B, DENEGADO_A, DENEGADO_B, BLOQUEADO_A, BLOQUEADO_B}, 0);
   endtask

   task automatic wait_sesion(input bit who);
      bit ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         ciclo();
         if ((who ? CONCEDIDO_B : CONCEDIDO_A) && !SOLICITUD_ACCESO) ok = 1'b1;
      end
      chk("grant_wait", 32'(ok), 1);
   endtask

   task automatic digito(input bit who, input logic [3:0] d);
      q_dig.push_back(d);
      if (who) begin DIGITO_B = d; DIGITO_STB_B = 1'b1; end
      else     begin DIGITO_A = d; DIGITO_STB_A = 1'b1; end
      ciclo();
      DIGITO_STB_A = 1'b0;
      DIGITO_STB_B = 1'b0;
   endtask

   // res[0] = ACCESO_ACEPTADO, res[1] = ACCESO_DENEGADO
   task automatic resultado(input bit who, input logic [1:0] res);
      if (res[1]) q_res.push_back(who ? 4'b0001 : 4'b0010);
      else        q_res.push_back(who ? 4'b0100 : 4'b1000);
      ACCESO_ACEPTADO = res[0];
      ACCESO_DENEGADO = res[1];
      ciclo();
      ACCESO_ACEPTADO = 1'b0;
      ACCESO_DENEGADO = 1'b0;
      ciclo();
   endtask

   task automatic sesion(input bit who, input int ndig, input logic [3:0] d0, input logic [1:0] res);
      q_grant.push_back(who ? 2'b01 : 2'b10);
      set_req(who, 1'b1);
      wait_sesion(who);
      set_req(who, 1'b0);
      chk("other_not_granted", 32'(who ? CONCEDIDO_A : CONCEDIDO_B), 0);
      for (int i = 0; i < ndig; i++) digito(who, d0 + 4'(i));
      resultado(who, res);
   endtask

   task automatic do_reset(input string n);
      RESET = 1'b0;
      #1;
      chk_cero(n);
      ciclo();
      RESET = 1'b1;
      ciclo();
   endtask

   initial begin
      int n;
      #12;
      chk_cero("reset_outputs");
      RESET = 1'b1;
      ciclo();

      // Single grant, four digits, accepted
      sesion(1'b0, 4, 4'd3, 2'b01);

      // Contention after reset: A first, B strobes ignored, then B
      do_reset("reset_between");
      q_grant.push_back(2'b10);
      q_grant.push_back(2'b01);
      SOLICITUD_A = 1'b1;
      SOLICITUD_B = 1'b1;
      wait_sesion(1'b0);
      SOLICITUD_A = 1'b0;
      chk("b_not_granted", 32'(CONCEDIDO_B), 0);
      DIGITO_B = 4'd9;
      digito(1'b0, 4'd6);
      DIGITO_B = 4'd9; DIGITO_STB_B = 1'b1;
      ciclo();
      DIGITO_STB_B = 1'b0;
      resultado(1'b0, 2'b10);
      wait_sesion(1'b1);
      SOLICITUD_B = 1'b0;
      digito(1'b1, 4'd5);
      resultado(1'b1, 2'b01);

      // Same-cycle accept and deny: only the denial pulses
      sesion(1'b0, 1, 4'd7, 2'b11);

      // Result inputs outside a session produce nothing
      ACCESO_ACEPTADO = 1'b1;
      ciclo();
      ACCESO_ACEPTADO = 1'b0;
      ciclo();

      // Lockout of B after three denials; A still served
      sesion(1'b1, 1, 4'd1, 2'b10);
      sesion(1'b1, 1, 4'd1, 2'b10);
      chk("lock_b_not_yet", 32'(BLOQUEADO_B), 0);
      blk_b = 0;
      sesion(1'b1, 1, 4'd1, 2'b10);
      chk("lock_b_set", 32'(BLOQUEADO_B), 1);
      SOLICITUD_B = 1'b1;
      sesion(1'b0, 2, 4'd2, 2'b01);
      chk("lock_b_held", 32'(BLOQUEADO_B), 1);
      q_grant.push_back(2'b01);
      n = 0;
      while (BLOQUEADO_B && n < 100) begin ciclo(); n++; end
      chk("lock_b_len_ok", 32'(blk_b >= 64 && blk_b <= 65), 1);
      wait_sesion(1'b1);
      SOLICITUD_B = 1'b0;
      digito(1'b1, 4'd8);
      resultado(1'b1, 2'b01);

      // Reset during a session: outputs drop at once, no result pulse
      q_grant.push_back(2'b10);
      SOLICITUD_A = 1'b1;
      wait_sesion(1'b0);
      SOLICITUD_A = 1'b0;
      do_reset("reset_mid_session");
      repeat (3) ciclo();
      chk("idle_after_reset", {CONCEDIDO_A, CONCEDIDO_B}, 0);

      // Timeout: 16 idle cycles abort with a denial counted as a failure
      q_grant.push_back(2'b10);
      q_res.push_back(4'b0010);
      SOLICITUD_A = 1'b1;
      wait_sesion(1'b0);
      SOLICITUD_A = 1'b0;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         ciclo();
         n++;
         if (DENEGADO_A) break;
      end
      chk("timeout_cycles", n, 16);
      ciclo();
      chk("timeout_released", 32'(CONCEDIDO_A), 0);
      sesion(1'b0, 1, 4'd4, 2'b10);
      chk("lock_a_after_2", 32'(BLOQUEADO_A), 0);
      sesion(1'b0, 1, 4'd4, 2'b10);
      chk("lock_a_after_3", 32'(BLOQUEADO_A), 1);

      repeat (2) ciclo();
      chk("grant_queue_empty", q_grant.size(), 0);
      chk("digit_queue_empty", q_dig.size(), 0);
      chk("result_queue_empty", q_res.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule
